// File: rtl/dbus_xbar.sv
// N-way data-bus router: decodes a target from an address field, runs one request at a time.
// Optional macro XBAR_TIMEOUT_EN adds a stall timeout that answers with an error response.
module dbus_xbar #(
  parameter int N_TGT   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 30,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [DATA_W/8-1:0]      req_be,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [N_TGT-1:0]         tgt_valid,
  output logic                     tgt_we,
  output logic [DATA_W/8-1:0]      tgt_be,
  output logic [ADDR_W-1:0]        tgt_addr,
  output logic [DATA_W-1:0]        tgt_wdata,
  input  logic [N_TGT-1:0]         tgt_ready,
  input  logic [N_TGT-1:0]         tgt_rvalid,
  input  logic [N_TGT*DATA_W-1:0]  tgt_rdata,
  input  logic [N_TGT-1:0]         tgt_err,
  output logic [7:0]               err_count
);

  localparam int SW = SEL_HI - SEL_LO + 1;
  localparam int IDXW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam logic [31:0] N_TGT_U = 32'(N_TGT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]     sel_field;
  logic              mapped;
  logic              accept;
  logic [N_TGT-1:0]  dec_onehot;
  logic [IDXW-1:0]   idx_q;
  logic              sel_ready, sel_rvalid, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              complete, tmo_hit;
  logic              rsp_fire, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  assign sel_field = req_addr[SEL_HI:SEL_LO];
  assign mapped    = (32'(sel_field) < N_TGT_U);
  assign accept    = (state == S_IDLE) && req_valid;

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < N_TGT; i++)
      dec_onehot[i] = (32'(sel_field) == 32'(i));
  end

  // Only the latched target's handshake and response lines are ever looked at.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rvalid = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (32'(idx_q) == 32'(i)) begin
        sel_ready  = tgt_ready[i];
        sel_rvalid = tgt_rvalid[i];
        sel_err    = tgt_err[i];
        sel_rdata  = tgt_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign complete = ((state == S_ISSUE) && sel_ready && sel_rvalid) ||
                    ((state == S_WAIT) && sel_rvalid);

`ifdef XBAR_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST) &&
                   (((state == S_ISSUE) && !sel_ready) ||
                    ((state == S_WAIT) && !sel_rvalid));

  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else if (accept || ((state == S_ISSUE) && sel_ready))
      tmo_cnt <= '0;
    else if ((state == S_ISSUE) || (state == S_WAIT))
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = mapped ? S_ISSUE : S_ERR;
      S_ISSUE: if (tmo_hit) state_nxt = S_IDLE;
               else if (sel_ready) state_nxt = sel_rvalid ? S_IDLE : S_WAIT;
      S_WAIT:  if (sel_rvalid || tmo_hit) state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Error responses (unmapped or timed out) always carry zero data; writes return zero too.
  always_comb begin
    req_ready     = (state == S_IDLE);
    rsp_fire      = complete || tmo_hit || (state == S_ERR);
    rsp_err_nxt   = ((state == S_ERR) || tmo_hit) ? 1'b1 : sel_err;
    rsp_rdata_nxt = ((state == S_ERR) || tmo_hit || tgt_we) ? '0 : sel_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_count <= '0;
      tgt_valid <= '0;
      tgt_we    <= 1'b0;
      tgt_be    <= '0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      idx_q     <= '0;
    end else begin
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_err   <= rsp_err_nxt;
        rsp_rdata <= rsp_rdata_nxt;
        if (rsp_err_nxt && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end
      if (accept) begin
        tgt_we    <= req_we;
        tgt_be    <= req_be;
        tgt_addr  <= req_addr;
        tgt_wdata <= req_wdata;
        idx_q     <= IDXW'(sel_field);
        tgt_valid <= mapped ? dec_onehot : '0;
      end else if ((state == S_ISSUE) && (sel_ready || tmo_hit)) begin
        tgt_valid <= '0;
      end
    end
  end

endmodule
